// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and constants for the multiply/divide unit
package muldiv_pkg;
    localparam int DATA_W = 32;
    localparam int ITER_LAST = DATA_W - 1;
    localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: turns the unsigned-magnitude product or quotient/remainder into signed HI/LO
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               is_signed,
    input  logic               is_div,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic               neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Product and quotient flip when operand signs differ; remainder follows the dividend
    always_comb begin
        neg  = is_signed && (sign_a ^ sign_b);
        prod = neg ? -raw : raw;
        quo  = neg ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        rem  = (is_signed && sign_a) ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        hi   = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo   = is_div ? quo : prod[WIDTH-1:0];
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO; MULDIV_FAST_MUL_EN selects a one-cycle multiply
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               signed_q, signed_d;
    logic               div_q, div_d;
    logic               div0_q, div0_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     step;
    logic [WIDTH-1:0]   mag_a, mag_b, fix_hi, fix_lo;
    logic               op_div, op_signed, sa, sb;
    op_e                op_c;

    // Decode the incoming op and form operand magnitudes for capture
    always_comb begin
        op_c      = op_e'(op);
        op_div    = op_c == OP_DIVU || op_c == OP_DIV;
        op_signed = op_c == OP_MULT || op_c == OP_DIV;
        sa        = op_signed && a[WIDTH-1];
        sb        = op_signed && b[WIDTH-1];
        mag_a     = sa ? -a : a;
        mag_b     = sb ? -b : b;
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .raw       (acc_q),
        .sign_a    (sign_a_q),
        .sign_b    (sign_b_q),
        .is_signed (signed_q),
        .is_div    (div_q),
        .hi        (fix_hi),
        .lo        (fix_lo)
    );

    // FSM and datapath: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        signed_d = signed_q;
        div_d    = div_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        step     = '0;
        case (state_q)
            IDLE: begin
                hi_d  = mthi ? a : hi_q;
                lo_d  = mtlo ? a : lo_q;
                cnt_d = '0;
                if (start) begin
                    state_d  = op_div ? DIV : MUL;
                    sign_a_d = sa;
                    sign_b_d = sb;
                    signed_d = op_signed;
                    div_d    = op_div;
                    div0_d   = op_div && b == '0;
                    a_raw_d  = a;
                    acc_d    = {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                    opnd_d   = op_div ? mag_b : mag_a;
                end
            end
            MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                acc_d   = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
                state_d = FIX;
`else
                step    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
                acc_d   = {step, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'(ITER_LAST) ? FIX : MUL;
`endif
            end
            DIV: begin
                step    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
                acc_d   = step[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {step[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'(ITER_LAST) ? FIX : DIV;
            end
            FIX: begin
                hi_d    = div0_q ? a_raw_q : fix_hi;
                lo_d    = div0_q ? DIV0_LO : fix_lo;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
        done_d = state_q == FIX;
        dbz_d  = done_d && div0_q;
    end

    // State, architectural HI/LO and registered status outputs
    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        acc_q    <= acc_d;
        opnd_q   <= opnd_d;
        a_raw_q  <= a_raw_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
        signed_q <= signed_d;
        div_q    <= div_d;
        div0_q   <= div0_d;
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // Spec latency: start at edge k, done in the cycle ending at edge k+lat
    function automatic int lat(input logic [1:0] o);
        return (FAST && !o[1]) ? 3 : 34;
    endfunction

    function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        int          sx, sy;
        longint      q, r;
        sx = x;
        sy = y;
        e.dbz = 1'b0;
        e.due = 0;
        case (o)
            2'b00: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = 64'(longint'(sx) * longint'(sy)); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b10: begin
                if (y == 0) begin e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
            default: begin
                if (y == 0) begin e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; end
                else begin
                    q = longint'(sx) / longint'(sy);
                    r = longint'(sx) % longint'(sy);
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Called at a negedge while the unit is idle; returns at the following negedge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = ref_model(o, x, y);
        e.due = cyc + lat(o);
        exp_q.push_back(e);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nb);
        nb = 0;
        while (!done && nb < 100) begin
            if (busy) nb++;
            @(negedge clk);
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: actual no done required done (cycle %0d)", cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: actual done required none (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_hi", hi, mon_e.hi);
                chk("res_lo", lo, mon_e.lo);
                chk("res_dbz", 32'(div_by_zero), 32'(mon_e.dbz));
                chk("done_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: actual unfinished required finished");
        $fatal(1, "timeout");
    end

    logic [1:0]  d_op [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
    logic [31:0] d_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFE};
    logic [31:0] d_b  [6] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd3};

    initial begin
        int nb;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_dbz", 32'(div_by_zero), 32'h0);

        for (int i = 0; i < 6; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_done(nb);
            chk("busy_cycles", nb, lat(d_op[i]) - 1);
        end

        // mthi/mtlo in idle (here the done cycle)
        mthi = 1'b1; a = 32'hAAAA_5555;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; a = 32'h5555_AAAA;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mthi_idle", hi, 32'hAAAA_5555);
        chk("mtlo_idle", lo, 32'h5555_AAAA);

        // Second start plus mthi at k+5 are ignored; HI/LO hold pre-op values
        issue(2'b10, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'd3; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("hi_hold_busy", hi, 32'hAAAA_5555);
        chk("lo_hold_busy", lo, 32'h5555_AAAA);
        chk("busy_mid", 32'(busy), 32'h1);
        wait_done(nb);

        // Start plus mtlo in the done cycle
        mtlo = 1'b1;
        issue(2'b00, 32'h1234, 32'd5);
        mtlo = 1'b0;
        chk("mtlo_done_cycle", lo, 32'h1234);
        chk("busy_b2b", 32'(busy), 32'h1);
        wait_done(nb);

        // Reset mid-DIV aborts without a result
        issue(2'b11, 32'h1234_5678, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        reset = 1'b0;
        issue(2'b11, 32'hFFFF_FF00, 32'd7);
        wait_done(nb);
        chk("busy_cycles", nb, lat(2'b11) - 1);

        // Random back-to-back ops issued in each done cycle
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            issue(ro, ra, rb);
            wait_done(nb);
            chk("busy_cycles", nb, lat(ro) - 1);
        end

        repeat (40) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'h0);
        chk("final_busy", 32'(busy), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative MIPS multiply/divide unit holding the architectural HI/LO registers. Executes MULT, MULTU, DIV and DIVU on ID/EX operands a, b. It sits beside the bitwise/arithmetic units in the execute stage. Its hi/lo outputs feed the execute-stage result mux for MFHI/MFLO. busy drives the hazard unit, which stalls MFHI/MFLO and new mul/div ops.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  launch op; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
mthi  input  1  write a into HI (MTHI)
mtlo  input  1  write a into LO (MTLO)
busy  output  1  operation in flight
done  output  1  one-cycle pulse; hi/lo hold new result this cycle
div_by_zero  output  1  pulses with done when a DIV/DIVU had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high) clears hi, lo, busy, done and div_by_zero to 0 and state to IDLE. It aborts any in-flight op without updating HI/LO.
- States:
  - IDLE: on start go to MUL if op[1]==0, else DIV.
  - MUL/DIV: run WIDTH iterations with a 5-bit counter (0..WIDTH-1), then go to FIX.
  - FIX: sign correction and HI/LO write, then go to IDLE.
- Operand capture at start:
  - Signed ops store |a|, |b| as unsigned magnitudes and latch sign_a, sign_b.
  - Unsigned ops store raw values.
- Latency:
  - start sampled high at edge k; busy=1 in cycles k+1..k+33.
  - hi/lo updated at edge k+34; done=1 and busy=0 during cycle k+34.
  - Back-to-back start is allowed in the done cycle.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH product. Signed: negate the product if sign_a^sign_b. hi=product[63:32], lo=product[31:0].
- DIV: restoring, one quotient bit per cycle. Signed: quotient negated if sign_a^sign_b; remainder takes sign_a. lo=quotient, hi=remainder.
- DIV of 0x80000000 by 0xFFFFFFFF (signed): lo=0x80000000, hi=0 (no trap).
- Divide by zero (b==0): still takes full latency; hi=a (original), lo=0xFFFFFFFF, div_by_zero=1 with done.
- start while busy: ignored, no queuing.
- mthi/mtlo:
  - In IDLE (including the done cycle) they write a into HI/LO at the next edge.
  - While busy they are ignored.
  - mthi with start in the same cycle: both honoured; the later result overwrites HI.
- hi/lo are stable and readable during busy; they show the pre-op values until the result write.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULTU use a single-cycle combinational multiply. The MUL state lasts 1 cycle, then FIX; done occurs at k+3. DIV latency is unchanged.
- Undefined: iterative multiply, latency as specified above.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state enum IDLE/MUL/DIV/FIX
  - ITER_LAST=WIDTH-1
  - DIV0_LO constant 0xFFFFFFFF
- Sub-module muldiv_sign_fix (combinational): takes the raw 2*WIDTH result, sign_a, sign_b and op class. Outputs corrected hi/lo. Used in FIX.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at k+34, hi=0xFFFFFFFE, lo=0x00000001, busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div_by_zero=1 with done. Signed DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start at k, second start and mthi at k+5 -> both ignored, result equals first op only. In the done cycle, start plus mtlo=0x1234 -> lo=0x1234 next cycle, new op proceeds.
- reset asserted at k+10 mid-DIV -> next cycle busy=0, hi=lo=0, done never pulses. Fresh start afterwards gives correct result.
- With MULDIV_FAST_MUL_EN: MULT a=-2, b=3 -> done at k+3, hi=0xFFFFFFFF, lo=0xFFFFFFFA; DIVU still k+34.
